// File: rtl/mem_wb_queue.sv
// mem_wb_queue: DEPTH-entry in-order queue between the MEM stage and the
// register-file write port. It replaces a single MEM/WB register so the
// write-back side can stall without freezing MEM.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   flush           synchronous discard of every queued entry
//   mem_valid/ready MEM-side handshake; mem_wd/mem_wreg/mem_wdata payload
//   wb_valid/ready  WB-side handshake; wb_wd/wb_wreg/wb_wdata head entry
//   wb_count        current occupancy (0..DEPTH)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. mem_ready comes from registered occupancy only (never from
// wb_ready), so a full queue does not pass data through in the same cycle.
// While wb_valid=1 and wb_ready=0 the wb_* payload is held constant.
module mem_wb_queue #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int ZERO_GUARD = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_wd,
  input  logic                     mem_wreg,
  input  logic [DATA_W-1:0]        mem_wdata,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [ADDR_W-1:0]        wb_wd,
  output logic                     wb_wreg,
  output logic [DATA_W-1:0]        wb_wdata,
  output logic [$clog2(DEPTH):0]   wb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wd_mem   [DEPTH];
  logic              wreg_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic not_empty;
  logic push;
  logic pop;
  logic wreg_guarded;

  always_comb begin
    not_empty    = (count != '0);
    mem_ready    = !rst && (count < FULL_COUNT);
    push         = mem_valid && mem_ready && !flush;
    pop          = not_empty && wb_ready && !flush;
    // Writes to x0 are kept as entries but never enable the regfile write.
    wreg_guarded = mem_wreg && !((ZERO_GUARD != 0) && (mem_wd == '0));
  end

  // Occupancy and pointers. Full/empty comes from count, so pointers are
  // free to wrap at DEPTH without an extra lap bit.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage is not cleared on reset or flush; count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      wd_mem[wr_ptr]   <= mem_wd;
      wreg_mem[wr_ptr] <= wreg_guarded;
      data_mem[wr_ptr] <= mem_wdata;
    end
  end

  always_comb begin
    wb_valid = not_empty;
    wb_count = count;
    wb_wd    = not_empty ? wd_mem[rd_ptr]   : '0;
    wb_wreg  = not_empty ? wreg_mem[rd_ptr] : 1'b0;
    wb_wdata = not_empty ? data_mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_mem_wb_queue.sv
module tb_mem_wb_queue;

  // ---------------- clock / reset / shared stimulus ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_wd = '0;
  logic        mem_wreg = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic        wb_ready = 1'b0;

  always #5 clk = ~clk;

  // Two instances share stimulus: DEPTH=2 and DEPTH=4.
  logic        d2_mem_ready, d2_wb_valid, d2_wb_wreg;
  logic [4:0]  d2_wb_wd;
  logic [31:0] d2_wb_wdata;
  logic [1:0]  d2_wb_count;
  logic        d4_mem_ready, d4_wb_valid, d4_wb_wreg;
  logic [4:0]  d4_wb_wd;
  logic [31:0] d4_wb_wdata;
  logic [2:0]  d4_wb_count;

  mem_wb_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .ZERO_GUARD(1)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(d2_mem_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .wb_valid(d2_wb_valid), .wb_ready(wb_ready),
    .wb_wd(d2_wb_wd), .wb_wreg(d2_wb_wreg), .wb_wdata(d2_wb_wdata),
    .wb_count(d2_wb_count)
  );

  mem_wb_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(4), .ZERO_GUARD(1)) u_d4 (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(d4_mem_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .wb_valid(d4_wb_valid), .wb_ready(wb_ready),
    .wb_wd(d4_wb_wd), .wb_wreg(d4_wb_wreg), .wb_wdata(d4_wb_wdata),
    .wb_count(d4_wb_count)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit model_live = 1'b0;

  // Entry layout: {wd[4:0], wreg, data[31:0]}
  logic [37:0] exp_q2[$];
  logic [37:0] exp_q4[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of entries, updated once per rising edge.
  always @(posedge clk) begin
    logic [37:0] e;
    bit push2, push4, pop2, pop4;
    e = {mem_wd, mem_wreg && (mem_wd != 5'd0), mem_wdata};
    if (rst) begin
      exp_q2.delete();
      exp_q4.delete();
      model_live = 1'b1;
    end else if (flush) begin
      exp_q2.delete();
      exp_q4.delete();
    end else begin
      push2 = mem_valid && (exp_q2.size() < 2);
      push4 = mem_valid && (exp_q4.size() < 4);
      pop2  = wb_ready && (exp_q2.size() != 0);
      pop4  = wb_ready && (exp_q4.size() != 0);
      if (pop2) void'(exp_q2.pop_front());
      if (pop4) void'(exp_q4.pop_front());
      if (push2) exp_q2.push_back(e);
      if (push4) exp_q4.push_back(e);
    end
  end

  // Compare process: every falling edge once the model has seen a reset.
  always @(negedge clk) begin
    logic [37:0] h2, h4;
    if (model_live) begin
      h2 = (exp_q2.size() != 0) ? exp_q2[0] : 38'd0;
      h4 = (exp_q4.size() != 0) ? exp_q4[0] : 38'd0;
      check("d2 wb_valid",  64'(d2_wb_valid),  64'(exp_q2.size() != 0));
      check("d2 wb_count",  64'(d2_wb_count),  64'(exp_q2.size()));
      check("d2 mem_ready", 64'(d2_mem_ready), 64'(!rst && exp_q2.size() < 2));
      check("d2 wb_wd",     64'(d2_wb_wd),     64'(h2[37:33]));
      check("d2 wb_wreg",   64'(d2_wb_wreg),   64'(h2[32]));
      check("d2 wb_wdata",  64'(d2_wb_wdata),  64'(h2[31:0]));
      check("d4 wb_valid",  64'(d4_wb_valid),  64'(exp_q4.size() != 0));
      check("d4 wb_count",  64'(d4_wb_count),  64'(exp_q4.size()));
      check("d4 mem_ready", 64'(d4_mem_ready), 64'(!rst && exp_q4.size() < 4));
      check("d4 wb_wd",     64'(d4_wb_wd),     64'(h4[37:33]));
      check("d4 wb_wreg",   64'(d4_wb_wreg),   64'(h4[32]));
      check("d4 wb_wdata",  64'(d4_wb_wdata),  64'(h4[31:0]));
    end
  end

  // ---------------- driver ----------------
  // Apply inputs, then return 1 time unit after the next rising edge.
  task automatic cyc(input logic v, input logic [4:0] wd, input logic wr,
                     input logic [31:0] d, input logic rdy, input logic fl,
                     input logic r);
    mem_valid = v;
    mem_wd    = wd;
    mem_wreg  = wr;
    mem_wdata = d;
    wb_ready  = rdy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++) cyc(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int rdy_pct;

    // Reset
    cyc(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("lit reset wb_valid", 64'(d4_wb_valid), 64'd0);
    check("lit reset wb_count", 64'(d4_wb_count), 64'd0);

    // Single push, consumed immediately
    cyc(1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    check("lit single wb_valid", 64'(d4_wb_valid), 64'd1);
    check("lit single wb_wd",    64'(d4_wb_wd),    64'd5);
    check("lit single wb_wdata", 64'(d4_wb_wdata), 64'hDEADBEEF);
    cyc(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("lit single drained valid", 64'(d4_wb_valid), 64'd0);
    check("lit single drained data",  64'(d4_wb_wdata), 64'd0);

    // Fill DEPTH=2 with the WB side stalled
    cyc(1'b1, 5'd1, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd2, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    check("lit d2 full mem_ready", 64'(d2_mem_ready), 64'd0);
    cyc(1'b1, 5'd3, 1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    check("lit d2 full count", 64'(d2_wb_count), 64'd2);
    check("lit d2 full head",  64'(d2_wb_wdata), 64'h11);
    check("lit d4 count3",     64'(d4_wb_count), 64'd3);
    cyc(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("lit d2 second head", 64'(d2_wb_wdata), 64'h22);
    drain();

    // Continuous push+pop, data 1..10
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 5'd3, 1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
      check("lit stream data",  64'(d4_wb_wdata), 64'(i));
      check("lit stream count", 64'(d4_wb_count), 64'd1);
    end
    drain();

    // Zero guard
    cyc(1'b1, 5'd0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    check("lit zg valid", 64'(d4_wb_valid), 64'd1);
    check("lit zg wreg",  64'(d4_wb_wreg),  64'd0);
    check("lit zg data",  64'(d4_wb_wdata), 64'h55);
    drain();

    // Flush with a simultaneous push
    cyc(1'b1, 5'd4, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd4, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd4, 1'b1, 32'hA3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd7, 1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
    check("lit flush count", 64'(d4_wb_count), 64'd0);
    check("lit flush valid", 64'(d4_wb_valid), 64'd0);
    cyc(1'b1, 5'd9, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    check("lit post flush count", 64'(d4_wb_count), 64'd1);
    check("lit post flush data",  64'(d4_wb_wdata), 64'h99);
    drain();

    // Reset while occupied
    cyc(1'b1, 5'd6, 1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd6, 1'b1, 32'hC2, 1'b0, 1'b0, 1'b0);
    check("lit pre rst count", 64'(d4_wb_count), 64'd2);
    rst = 1'b1;
    #1;
    check("lit rst mem_ready", 64'(d4_mem_ready), 64'd0);
    @(posedge clk);
    #1;
    check("lit rst count", 64'(d4_wb_count), 64'd0);
    check("lit rst valid", 64'(d4_wb_valid), 64'd0);
    cyc(1'b1, 5'd8, 1'b1, 32'hABC, 1'b0, 1'b0, 1'b0);
    check("lit post rst data", 64'(d4_wb_wdata), 64'hABC);
    drain();

    // Randomized traffic
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rdy_pct = $urandom_range(10, 95);
      cyc($urandom_range(0, 3) != 0,
          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
          $urandom_range(0, 3) != 0,
          $urandom(),
          $urandom_range(0, 99) < rdy_pct,
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 199) == 0);
    end
    drain();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
